jt6295_rom_arb: RTL and testbench

//  Shares the single external ADPCM ROM port between the phrase-table fetcher
//  (ctrl, 10-bit header address) and the NCH ADPCM channel data fetchers.

---
 rtl/jt6295_pkg.sv | 13 +
 rtl/jt6295_rom_arb_if.sv | 10 +
 rtl/jt6295_rr_pick.sv | 22 ++
 rtl/jt6295_rom_arb.sv | 158 +++++++++++++++
 tb/tb_jt6295_rom_arb.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 ROM arbiter slice.
// The FSM states and the ctrl header-address mapping live here.
package jt6295_pkg;
  localparam int JT6295_AW  = 18;
  localparam int JT6295_NCH = 4;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // The phrase table sits at the bottom of the ROM.
  function automatic logic [JT6295_AW-1:0] ctrl_rom_addr(input logic [9:0] a);
    return {{(JT6295_AW-10){1'b0}}, a};
  endfunction
endpackage

// File: rtl/jt6295_rom_arb_if.sv
// External ADPCM ROM port: the arbiter is master, the ROM model/controller is slave.
interface jt6295_rom_arb_if #(parameter int AW = jt6295_pkg::JT6295_AW);
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;

  modport master(output rom_addr, rom_cs, input rom_data, rom_ok);
  modport slave (input rom_addr, rom_cs, output rom_data, rom_ok);
endinterface

// File: rtl/jt6295_rr_pick.sv
// Combinational NCH-way round-robin picker: first set req bit at or after rr.
module jt6295_rr_pick #(
  parameter  int NCH = 4,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
)(
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  rr,
  output logic           valid,
  output logic [IW-1:0]  idx
);
  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      if (req[(int'(rr) + i) % NCH]) begin
        valid = 1'b1;
        idx   = IW'((int'(rr) + i) % NCH);
      end
    end
  end
endmodule

// File: rtl/jt6295_rom_arb.sv
// Shares the ADPCM ROM between the phrase-table fetcher and NCH channel fetchers.
// Optional one-entry byte cache: define JT6295_ROM_CACHE_EN.
module jt6295_rom_arb
  import jt6295_pkg::*;
#(
  parameter int AW    = JT6295_AW,
  parameter int NCH   = JT6295_NCH,
  parameter int WAITC = 1
)(
  input  logic              clk,
  input  logic              rstn,
  input  logic [9:0]        ctrl_addr,
  input  logic              ctrl_cs,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_cs,
  output logic [7:0]        dout,
  output logic              ctrl_ok,
  output logic [NCH-1:0]    ch_ok,
  jt6295_rom_arb_if.master  rom
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(WAITC + 1);

  state_t         st, st_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           gnt_ctrl, gnt_ctrl_nx;
  logic [IW-1:0]  gnt_idx, gnt_idx_nx, rr, rr_nx;
  logic [AW-1:0]  addr_q, addr_nx;
  logic           cs_q, cs_nx;
  logic [7:0]     dout_nx;
  logic           ctrl_ok_nx;
  logic [NCH-1:0] ch_ok_nx;

  logic           pick_vld;
  logic [IW-1:0]  pick_idx;
  logic [AW-1:0]  req_addr;
  logic           gnt_cs, fill, hit;
  logic [7:0]     hit_data;

  jt6295_rr_pick #(.NCH(NCH)) u_pick (
    .req   (ch_cs),
    .rr    (rr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign req_addr = ctrl_cs ? AW'(ctrl_rom_addr(ctrl_addr))
                            : ch_addr[int'(pick_idx)*AW +: AW];
  assign gnt_cs   = gnt_ctrl ? ctrl_cs : ch_cs[gnt_idx];
  assign fill     = (st == WAIT) && (cnt == '0) && rom.rom_ok;

`ifdef JT6295_ROM_CACHE_EN
  logic          c_vld;
  logic [AW-1:0] c_addr;
  logic [7:0]    c_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      c_vld  <= 1'b0;
      c_addr <= '0;
      c_data <= '0;
    end else if (fill) begin
      c_vld  <= 1'b1;
      c_addr <= addr_q;
      c_data <= rom.rom_data;
    end
  end

  assign hit      = c_vld && (c_addr == req_addr);
  assign hit_data = c_data;
`else
  assign hit      = 1'b0;
  assign hit_data = 8'd0;
`endif

  always_comb begin
    st_nx       = st;
    cnt_nx      = cnt;
    gnt_ctrl_nx = gnt_ctrl;
    gnt_idx_nx  = gnt_idx;
    rr_nx       = rr;
    addr_nx     = addr_q;
    cs_nx       = cs_q;
    dout_nx     = dout;
    ctrl_ok_nx  = 1'b0;
    ch_ok_nx    = '0;
    unique case (st)
      IDLE: begin
        if (ctrl_cs || pick_vld) begin
          gnt_ctrl_nx = ctrl_cs;
          gnt_idx_nx  = pick_idx;
          if (hit) begin
            // Cached byte: answer without touching the ROM.
            dout_nx    = hit_data;
            ctrl_ok_nx = ctrl_cs;
            if (!ctrl_cs) ch_ok_nx[pick_idx] = 1'b1;
            cs_nx      = 1'b0;
            st_nx      = DONE;
          end else begin
            addr_nx = req_addr;
            cs_nx   = 1'b1;
            cnt_nx  = CW'(WAITC);
            st_nx   = WAIT;
          end
        end else begin
          cs_nx = 1'b0;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nx = cnt - 1'b1;
        end else if (fill) begin
          // A requester that gave up still gets dout refreshed, just no ok.
          dout_nx = rom.rom_data;
          if (gnt_cs) begin
            ctrl_ok_nx = gnt_ctrl;
            if (!gnt_ctrl) ch_ok_nx[gnt_idx] = 1'b1;
          end
          st_nx = DONE;
        end
      end
      DONE: begin
        if (!gnt_ctrl) rr_nx = (gnt_idx == IW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
        st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st       <= IDLE;
      cnt      <= '0;
      gnt_ctrl <= 1'b0;
      gnt_idx  <= '0;
      rr       <= '0;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      dout     <= '0;
      ctrl_ok  <= 1'b0;
      ch_ok    <= '0;
    end else begin
      st       <= st_nx;
      cnt      <= cnt_nx;
      gnt_ctrl <= gnt_ctrl_nx;
      gnt_idx  <= gnt_idx_nx;
      rr       <= rr_nx;
      addr_q   <= addr_nx;
      cs_q     <= cs_nx;
      dout     <= dout_nx;
      ctrl_ok  <= ctrl_ok_nx;
      ch_ok    <= ch_ok_nx;
    end
  end

  assign rom.rom_addr = addr_q;
  assign rom.rom_cs   = cs_q;
endmodule

// File: tb/tb_jt6295_rom_arb.sv
// Directed bench for jt6295_rom_arb: vector table for arbitration order and
// timing, plus hand sequences for ROM stall, cs drop, reset abort and cache.
module tb_jt6295_rom_arb;
  localparam int AW = 18, NCH = 4, WAITC = 1;

  logic              clk = 1'b0, rstn = 1'b1;
  logic [9:0]        ctrl_addr = '0;
  logic              ctrl_cs = 1'b0;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_cs = '0;
  logic [7:0]        dout;
  logic              ctrl_ok;
  logic [NCH-1:0]    ch_ok;
  logic              rok = 1'b1;
  logic [AW-1:0]     chaddr [NCH];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  jt6295_rom_arb_if #(.AW(AW)) rom();

  jt6295_rom_arb #(.AW(AW), .NCH(NCH), .WAITC(WAITC)) dut (
    .clk(clk), .rstn(rstn), .ctrl_addr(ctrl_addr), .ctrl_cs(ctrl_cs),
    .ch_addr(ch_addr), .ch_cs(ch_cs), .dout(dout), .ctrl_ok(ctrl_ok),
    .ch_ok(ch_ok), .rom(rom)
  );

  for (genvar k = 0; k < NCH; k++) begin : g_addr
    assign ch_addr[k*AW +: AW] = chaddr[k];
  end

  // ROM contents: a fixed scramble of the address (0x00008 holds 0x5A).
  function automatic logic [7:0] romf(input logic [AW-1:0] a);
    return (a[7:0] ^ 8'h52) + a[15:8];
  endfunction
  assign rom.rom_data = romf(rom.rom_addr);
  assign rom.rom_ok   = rok;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester ids: 0..3 channels, 4 ctrl.
  typedef struct {
    logic       ctrl;
    logic [9:0] ca;
    logic [3:0] ch;
    int         n;
    int         ord [5];
  } vec_t;

  function automatic vec_t mk(input logic c, input logic [9:0] ca, input logic [3:0] ch,
                              input int n, input int o0, input int o1, input int o2,
                              input int o3, input int o4);
    vec_t v;
    v.ctrl = c; v.ca = ca; v.ch = ch; v.n = n;
    v.ord[0] = o0; v.ord[1] = o1; v.ord[2] = o2; v.ord[3] = o3; v.ord[4] = o4;
    return v;
  endfunction

  function automatic logic [AW-1:0] eaddr(input int id, input logic [9:0] ca);
    return (id == 4) ? {8'd0, ca} : chaddr[id];
  endfunction

  function automatic int ok_id();
    int id = -1;
    if (ctrl_ok) id = 4;
    else for (int k = 0; k < NCH; k++) if (ch_ok[k]) id = k;
    return id;
  endfunction

  // Raise the requests at a negedge (DUT idle), serve them, drop each cs on its ok.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc, got, last, id, extra;
    @(negedge clk);
    ctrl_addr = v.ca; ctrl_cs = v.ctrl; ch_cs = v.ch;
    cyc = -1; got = 0; last = 0;
    while (got < v.n && cyc < 100) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ctrl_ok || ch_ok != '0) begin
        id = ok_id();
        chk({tag, "_onehot"}, $countones({ctrl_ok, ch_ok}), 1);
        chk({tag, "_id"}, id, v.ord[got]);
        chk({tag, "_dout"}, dout, romf(eaddr(id, v.ca)));
        chk({tag, "_addr"}, rom.rom_addr, eaddr(id, v.ca));
        chk({tag, "_time"}, (got == 0) ? cyc : cyc - last, (got == 0) ? WAITC + 1 : WAITC + 3);
        last = cyc; got++;
        if (id == 4) ctrl_cs = 1'b0; else if (id >= 0) ch_cs[id] = 1'b0;
      end
    end
    if (got < v.n) chk({tag, "_timeout"}, got, v.n);
    ctrl_cs = 1'b0; ch_cs = '0;
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (ctrl_ok || ch_ok != '0) extra++;
    end
    chk({tag, "_quiet"}, extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    int oks, cs_hi, lat;
    logic [7:0] dcap;

    chaddr[0] = 18'h00100; chaddr[1] = 18'h0A234;
    chaddr[2] = 18'h1F0F0; chaddr[3] = 18'h3FFFF;
    // ctrl alone; all channels; ctrl vs ch2; ctrl vs ch1/ch3 (rr=3); rr=2 wrap cases
    vt[0] = mk(1'b1, 10'h008, 4'b0000, 1, 4, 0, 0, 0, 0);
    vt[1] = mk(1'b0, 10'h000, 4'b1111, 4, 0, 1, 2, 3, 0);
    vt[2] = mk(1'b1, 10'h3FF, 4'b0100, 2, 4, 2, 0, 0, 0);
    vt[3] = mk(1'b1, 10'h155, 4'b1010, 3, 4, 3, 1, 0, 0);
    vt[4] = mk(1'b0, 10'h000, 4'b0011, 2, 0, 1, 0, 0, 0);
    vt[5] = mk(1'b0, 10'h000, 4'b1001, 2, 3, 0, 0, 0, 0);

    #2 rstn = 1'b0;
    #20;
    chk("rst_rom_cs", rom.rom_cs, 0);
    chk("rst_rom_addr", rom.rom_addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ok", {ctrl_ok, ch_ok}, 0);
    @(negedge clk) rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // ROM stall: rom_ok low for 20 cycles, WAIT must hold with rom_cs up.
    @(negedge clk);
    rok = 1'b0; ch_cs = 4'b0100;
    oks = 0; cs_hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (rom.rom_cs) cs_hi++;
      if (ctrl_ok || ch_ok != '0) oks++;
    end
    chk("stall_cs", cs_hi, 20);
    chk("stall_ok", oks, 0);
    rok = 1'b1; oks = 0; dcap = '0;
    repeat (6) begin
      @(negedge clk);
      if (ch_ok[2]) begin dcap = dout; ch_cs[2] = 1'b0; end
      if (ctrl_ok || ch_ok != '0) oks++;
    end
    chk("stall_okcnt", oks, 1);
    chk("stall_dout", dcap, romf(chaddr[2]));

    // Requester gives up mid-WAIT: no ok, but dout still refreshed.
    @(negedge clk) ch_cs = 4'b1000;
    @(negedge clk) ch_cs = 4'b0000;
    oks = 0;
    repeat (6) begin
      @(negedge clk);
      if (ctrl_ok || ch_ok != '0) oks++;
    end
    chk("drop_ok", oks, 0);
    chk("drop_dout", dout, romf(chaddr[3]));

    // Reset in WAIT aborts asynchronously with no ok.
    @(negedge clk);
    rok = 1'b0; ctrl_addr = 10'h123; ctrl_cs = 1'b1;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_rom_cs", rom.rom_cs, 0);
    chk("arst_rom_addr", rom.rom_addr, 0);
    chk("arst_dout", dout, 0);
    chk("arst_ok", {ctrl_ok, ch_ok}, 0);
    ctrl_cs = 1'b0; oks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ctrl_ok || ch_ok != '0) oks++;
    end
    chk("arst_hold_ok", oks, 0);
    rok = 1'b1; rstn = 1'b1;
    run_vec(mk(1'b0, 10'h000, 4'b0010, 1, 1, 0, 0, 0, 0), "after_rst");

    // Same address twice: ch0 fetches, ch1 re-reads it.
    chaddr[0] = 18'h1F000; chaddr[1] = 18'h1F000;
    run_vec(mk(1'b0, 10'h000, 4'b0001, 1, 0, 0, 0, 0, 0), "rep_first");
    @(negedge clk) ch_cs = 4'b0010;
    lat = -1; cs_hi = 0; oks = 0; dcap = '0;
    while (oks == 0 && lat < 50) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (rom.rom_cs) cs_hi++;
      if (ch_ok[1]) begin oks++; dcap = dout; ch_cs = '0; end
    end
    @(negedge clk) if (rom.rom_cs) cs_hi++;
    chk("rep_ok", oks, 1);
    chk("rep_dout", dcap, romf(18'h1F000));
`ifdef JT6295_ROM_CACHE_EN
    chk("rep_lat", lat, 0);
    chk("rep_rom_cs", cs_hi, 0);
`else
    chk("rep_lat", lat, WAITC + 1);
    chk("rep_rom_cs", (cs_hi > 0) ? 1 : 0, 1);
`endif
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
